// File: rtl/apx_pkg.sv
// Shared types and default constants for the approximate product accumulator.
// Optional saturating accumulate is enabled by defining APX_ACC_SAT_EN.
package apx_pkg;

  localparam int APX_PROD_W  = 8;
  localparam int APX_ACC_LEN = 8;
  localparam int APX_ACC_W   = 16;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } apx_state_t;

endpackage

// File: rtl/apx_beat_counter.sv
// Beat counter for one accumulation block.
// Wraps to zero on the beat that hits the terminal count.
module apx_beat_counter #(
  parameter int LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = (LEN > 2) ? $clog2(LEN) : 1;

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/apx_product_accumulator.sv
// Sums ACC_LEN approximate products per block with sticky overflow.
// Define APX_ACC_SAT_EN to clamp instead of wrapping on overflow.
module apx_product_accumulator
  import apx_pkg::*;
#(
  parameter int ACC_LEN = APX_ACC_LEN,
  parameter int ACC_W   = APX_ACC_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [APX_PROD_W-1:0] in_prod,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [ACC_W-1:0]      out_sum,
  output logic                  out_ovf,
  input  logic                  out_ready
);

  apx_state_t       state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             beat;
  logic             done;
  logic             tc;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] nxt;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

  assign beat = in_valid & in_ready & ~clr;
  assign done = out_valid & out_ready & ~clr;

  assign sum = {1'b0, acc}
             + {{(ACC_W + 1 - APX_PROD_W){1'b0}}, in_prod};

`ifdef APX_ACC_SAT_EN
  assign nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign nxt = sum[ACC_W-1:0];
`endif

  apx_beat_counter #(
    .LEN (ACC_LEN)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (beat),
    .tc    (tc)
  );

  // acc doubles as the result register; it is frozen while in OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      state <= ACC;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (beat) begin
      acc <= nxt;
      ovf <= ovf | sum[ACC_W];
      if (tc) state <= OUT;
    end else if (done) begin
      state <= ACC;
      acc   <= '0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apx_product_accumulator.sv
// Randomized self-checking bench for apx_product_accumulator.
// Covers default and narrow (ACC_W=8, ACC_LEN=2) builds.
module tb_apx_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [7:0]  in_prod;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_sum;
  logic        out_ovf;
  logic        out_ready;

  logic        v8;
  logic [7:0]  p8;
  logic        rdy8;
  logic        ov8;
  logic [7:0]  s8;
  logic        of8;
  logic        r8;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_out;
  int unsigned m_tot;
  int          m_n;

  always #5 clk = ~clk;

  apx_product_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_prod   (in_prod),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_ready (out_ready)
  );

  apx_product_accumulator #(
    .ACC_LEN (2),
    .ACC_W   (8)
  ) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .in_valid  (v8),
    .in_prod   (p8),
    .in_ready  (rdy8),
    .out_valid (ov8),
    .out_sum   (s8),
    .out_ovf   (of8),
    .out_ready (r8)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // block result from the plain arithmetic total of accepted beats
  function automatic int unsigned fold(int unsigned total, int w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
`ifdef APX_ACC_SAT_EN
    return (total > mx) ? mx : total;
`else
    return total & mx;
`endif
  endfunction

  function automatic bit ovf_of(int unsigned total, int w);
    return total > ((32'd1 << w) - 1);
  endfunction

  task automatic model_clear();
    m_out = 1'b0;
    m_tot = 0;
    m_n   = 0;
  endtask

  // check outputs at negedge, advance model, cross one posedge
  task automatic tick(string tag);
    chk({tag, ":rdy"}, 32'(in_ready), 32'(!m_out));
    chk({tag, ":vld"}, 32'(out_valid), 32'(m_out));
    if (m_out) begin
      chk({tag, ":sum"}, 32'(out_sum), fold(m_tot, 16));
      chk({tag, ":ovf"}, 32'(out_ovf), 32'(ovf_of(m_tot, 16)));
    end
    if (clr) begin
      model_clear();
    end else if (!m_out && in_valid) begin
      m_tot += in_prod;
      m_n++;
      if (m_n == 8) begin
        m_out = 1'b1;
        m_n   = 0;
      end
    end else if (m_out && out_ready) begin
      model_clear();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(bit v, int p, bit r, bit c);
    in_valid  = v;
    in_prod   = 8'(p);
    out_ready = r;
    clr       = c;
  endtask

  task automatic beats(string tag, int n, int p, bit r);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, p, r, 1'b0);
      tick(tag);
    end
  endtask

  task automatic async_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, ":rst_vld"}, 32'(out_valid), 0);
    chk({tag, ":rst_sum"}, 32'(out_sum), 0);
    chk({tag, ":rst_ovf"}, 32'(out_ovf), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int got;
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    v8 = 1'b0; p8 = '0; r8 = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("reset_vld", 32'(out_valid), 0);
    chk("reset_sum", 32'(out_sum), 0);
    chk("reset_ovf", 32'(out_ovf), 0);
    rst_n = 1'b1;
    drive(1'b0, 0, 1'b1, 1'b0);
    tick("idle");

    beats("def", 8, 225, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b0);
    chk("def_lat", 32'(out_valid), 1);
    chk("def_1800", 32'(out_sum), 1800);
    tick("def_out");
    tick("def_post");

    beats("bp", 8, 225, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 77, 1'b0, 1'b0);
      tick("bp_hold");
    end
    drive(1'b1, 77, 1'b1, 1'b0);
    tick("bp_xfer");
    beats("bp_new", 8, 3, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b0);
    tick("bp_new_out");

    beats("clr", 3, 10, 1'b1);
    drive(1'b1, 99, 1'b1, 1'b1);
    tick("clr_pulse");
    beats("clr_blk", 8, 1, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("clr_8", 32'(out_sum), 8);
    tick("clr_out");
    drive(1'b0, 0, 1'b1, 1'b0);
    tick("clr_xfer");

    beats("rst_mid", 3, 50, 1'b1);
    async_reset("mid");
    drive(1'b0, 0, 1'b1, 1'b0);
    tick("mid_post");
    beats("rst_out", 8, 40, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    tick("rst_out_hold");
    async_reset("out");
    beats("rst_full", 8, 12, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0);
    tick("rst_full_out");

    got = 0;
    for (int i = 0; i < 80 && got < 8; i++) begin
      if (!m_out && ($urandom_range(0, 1) == 1)) begin
        drive(1'b1, 15, 1'b0, 1'b0);
        got++;
      end else begin
        drive(1'b0, 15, 1'b0, 1'b0);
      end
      tick("gap");
    end
    chk("gap_beats", 32'(got), 8);
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("gap_120", 32'(out_sum), 120);
    tick("gap_out");
    drive(1'b0, 0, 1'b1, 1'b0);
    tick("gap_xfer");

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 255),
            $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
      tick("rnd");
    end
    drive(1'b0, 0, 1'b1, 1'b1);
    tick("rnd_end");

    v8 = 1'b1; p8 = 8'd200; r8 = 1'b0;
    @(negedge clk);
    p8 = 8'd100;
    @(negedge clk);
    v8 = 1'b0; p8 = 8'd55;
    chk("n8_vld", 32'(ov8), 1);
    chk("n8_rdy", 32'(rdy8), 0);
    chk("n8_sum", 32'(s8), fold(300, 8));
    chk("n8_ovf", 32'(of8), 1);
    @(negedge clk);
    chk("n8_hold", 32'(s8), fold(300, 8));
    r8 = 1'b1;
    @(negedge clk);
    r8 = 1'b0;
    chk("n8_done", 32'(ov8), 0);
    v8 = 1'b1; p8 = 8'd5;
    @(negedge clk);
    p8 = 8'd6;
    @(negedge clk);
    v8 = 1'b0;
    chk("n8_sum2", 32'(s8), fold(11, 8));
    chk("n8_ovf2", 32'(of8), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
